// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard interface: the front end drives the decoded instruction fields
// and receives stall/forwarding decisions back from pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDRESS_LENGTH = 5
);
  logic                          id_valid;
  logic [REG_ADDRESS_LENGTH-1:0] id_rA;
  logic [REG_ADDRESS_LENGTH-1:0] id_rB;
  logic                          id_rA_used;
  logic                          id_rB_used;
  logic                          id_wr_en;
  logic [REG_ADDRESS_LENGTH-1:0] id_rd;
  logic                          id_is_load;
  logic                          id_is_mul;
  logic                          stall;
  logic [1:0]                    fwd_sel_rA;
  logic [1:0]                    fwd_sel_rB;
  logic                          mul_busy;

  modport master (
    output id_valid, id_rA, id_rB, id_rA_used, id_rB_used,
           id_wr_en, id_rd, id_is_load, id_is_mul,
    input  stall, fwd_sel_rA, fwd_sel_rB, mul_busy
  );

  modport slave (
    input  id_valid, id_rA, id_rB, id_rA_used, id_rB_used,
           id_wr_en, id_rd, id_is_load, id_is_mul,
    output stall, fwd_sel_rA, fwd_sel_rB, mul_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: shadows EX/MEM/WB destinations,
// produces EX operand forwarding selects and stalls on load-use or a busy multiplier.
module pipe_hazard_ctrl #(
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int MUL_LATENCY        = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

  typedef logic [REG_ADDRESS_LENGTH-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    logic  wr;
    addr_t rd;
    logic  load;
    logic  mul;
  } entry_t;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_MUL_BUSY
  } hazard_e;

  entry_t           ex_q, ex_d;
  entry_t           mem_q, mem_d;
  entry_t           wb_q, wb_d;
  entry_t           id_entry;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic             mul_busy_q, mul_busy_d;
  hazard_e          hazard;
  logic             a_ex, a_mem, b_ex, b_mem;

  function automatic logic src_match(input logic used, input addr_t src, input entry_t e);
    return used && e.valid && e.wr && (e.rd == src);
  endfunction

  // The youngest producer wins; WB needs no forward because the regfile writes through.
  function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return 2'b01;
    else if (hit_mem) return 2'b10;
    else              return 2'b00;
  endfunction

  always_comb begin
    a_ex  = src_match(hz.id_rA_used, hz.id_rA, ex_q);
    a_mem = src_match(hz.id_rA_used, hz.id_rA, mem_q);
    b_ex  = src_match(hz.id_rB_used, hz.id_rB, ex_q);
    b_mem = src_match(hz.id_rB_used, hz.id_rB, mem_q);
    if (mul_cnt_q != '0)
      hazard = HZ_MUL_BUSY;
    else if (hz.id_valid && ex_q.load && (a_ex || b_ex))
      hazard = HZ_LOAD_USE;
    else
      hazard = HZ_NONE;
  end

  assign hz.stall      = !reset && (hazard != HZ_NONE);
  assign hz.fwd_sel_rA = fwd_a_q;
  assign hz.fwd_sel_rB = fwd_b_q;
  assign hz.mul_busy   = mul_busy_q;

  always_comb begin
    id_entry  = '{valid: hz.id_valid, wr: hz.id_wr_en, rd: hz.id_rd,
                  load: hz.id_is_load, mul: hz.id_is_mul};
    ex_d      = ex_q;
    mem_d     = ex_q;
    wb_d      = mem_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    mul_cnt_d = (mul_cnt_q != '0) ? mul_cnt_q - 1'b1 : '0;
    case (hazard)
      HZ_MUL_BUSY: begin
        mem_d = '0;
      end
      HZ_LOAD_USE: begin
        ex_d    = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end
      default: begin
        ex_d    = id_entry;
        fwd_a_d = hz.id_valid ? fwd_select(a_ex, a_mem) : 2'b00;
        fwd_b_d = hz.id_valid ? fwd_select(b_ex, b_mem) : 2'b00;
        if (hz.id_valid && hz.id_is_mul)
          mul_cnt_d = CNT_LOAD;
      end
    endcase
    mul_busy_d = (mul_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      mul_cnt_q  <= '0;
      fwd_a_q    <= 2'b00;
      fwd_b_q    <= 2'b00;
      mul_busy_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      mul_cnt_q  <= mul_cnt_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      mul_busy_q <= mul_busy_d;
    end
  end
endmodule
